// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 32-bit ARM core.
// Captures decoded control and data fields for the Execute stage. Instructions
// whose condition fails, or slots holding no instruction, pass through as
// bubbles: their data is kept, but all side-effect controls are cleared.
// A flush inserts an all-zero bubble. A freeze holds the current contents.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              cond_state,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [CMD_W-1:0]  exe_cmd_in,
    input  logic              imm_in,
    input  logic [3:0]        dest_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [3:0]        sr_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] pc_out,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              b_out,
    output logic              s_out,
    output logic [CMD_W-1:0]  exe_cmd_out,
    output logic              imm_out,
    output logic [3:0]        dest_out,
    output logic [DATA_W-1:0] val_rn_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm_24_out,
    output logic [3:0]        sr_out
);

    // A control bit may only take effect for a real instruction whose condition holds.
    logic take;
    assign take = cond_state & valid_in;

    // Control register: the flush bubble wins over a freeze; side effects are gated by take.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out    <= 1'b0;
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            mem_w_en_out <= 1'b0;
            b_out        <= 1'b0;
            s_out        <= 1'b0;
        end else if (flush) begin
            valid_out    <= 1'b0;
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            mem_w_en_out <= 1'b0;
            b_out        <= 1'b0;
            s_out        <= 1'b0;
        end else if (!freeze) begin
            valid_out    <= valid_in;
            wb_en_out    <= wb_en_in    & take;
            mem_r_en_out <= mem_r_en_in & take;
            mem_w_en_out <= mem_w_en_in & take;
            b_out        <= b_in        & take;
            s_out        <= s_in        & take;
        end
    end

    // Data register: zeroed by a flush, otherwise captured unconditionally unless frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out            <= '0;
            exe_cmd_out       <= '0;
            imm_out           <= 1'b0;
            dest_out          <= '0;
            val_rn_out        <= '0;
            val_rm_out        <= '0;
            shift_operand_out <= '0;
            signed_imm_24_out <= '0;
            sr_out            <= '0;
        end else if (flush) begin
            pc_out            <= '0;
            exe_cmd_out       <= '0;
            imm_out           <= 1'b0;
            dest_out          <= '0;
            val_rn_out        <= '0;
            val_rm_out        <= '0;
            shift_operand_out <= '0;
            signed_imm_24_out <= '0;
            sr_out            <= '0;
        end else if (!freeze) begin
            pc_out            <= pc_in;
            exe_cmd_out       <= exe_cmd_in;
            imm_out           <= imm_in;
            dest_out          <= dest_in;
            val_rn_out        <= val_rn_in;
            val_rm_out        <= val_rm_in;
            shift_operand_out <= shift_operand_in;
            signed_imm_24_out <= signed_imm_24_in;
            sr_out            <= sr_in;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Testbench for id_ex_stage_reg: directed vector table, freeze and reset
// sequences, and randomized traffic against a record-level reference model.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic [3:0]  exe_cmd;
        logic        imm;
        logic [3:0]  dest;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  sr;
    } fields_t;

    localparam int FW = $bits(fields_t);

    typedef struct {
        string   name;
        fields_t in;
        logic    cond;
        logic    flush;
        logic    freeze;
        fields_t exp;
    } vec_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    logic    flush = 1'b0;
    logic    freeze = 1'b0;
    logic    cond = 1'b0;
    fields_t din = '0;
    fields_t dout;
    fields_t mdl = '0;

    logic        valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [3:0]  exe_cmd_out, dest_out, sr_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DATA_W(32), .CMD_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .cond_state(cond),
        .valid_in(din.valid), .pc_in(din.pc), .wb_en_in(din.wb_en),
        .mem_r_en_in(din.mem_r_en), .mem_w_en_in(din.mem_w_en), .b_in(din.b),
        .s_in(din.s), .exe_cmd_in(din.exe_cmd), .imm_in(din.imm), .dest_in(din.dest),
        .val_rn_in(din.val_rn), .val_rm_in(din.val_rm),
        .shift_operand_in(din.shift_operand), .signed_imm_24_in(din.signed_imm_24),
        .sr_in(din.sr),
        .valid_out(valid_out), .pc_out(pc_out), .wb_en_out(wb_en_out),
        .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out), .b_out(b_out),
        .s_out(s_out), .exe_cmd_out(exe_cmd_out), .imm_out(imm_out), .dest_out(dest_out),
        .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
        .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
        .sr_out(sr_out)
    );

    assign dout = {valid_out, pc_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out,
                   exe_cmd_out, imm_out, dest_out, val_rn_out, val_rm_out,
                   shift_operand_out, signed_imm_24_out, sr_out};

    // Reference: what the EX slot should hold after one edge, as a whole record.
    function automatic fields_t model_next(fields_t cur, fields_t in, logic c, logic fl, logic fr);
        fields_t n;
        if (fl) return '0;
        if (fr) return cur;
        n = in;
        if (!(c && in.valid)) begin
            n.wb_en = 0; n.mem_r_en = 0; n.mem_w_en = 0; n.b = 0; n.s = 0;
        end
        return n;
    endfunction

    function automatic fields_t rand_fields();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return fields_t'(t[FW-1:0]);
    endfunction

    task automatic check(input string name, input fields_t act, input fields_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock edge with the current inputs; model follows; outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        mdl = model_next(mdl, din, cond, flush, freeze);
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        fields_t t;

        // Directed vectors.
        t = '0; t.valid = 1; t.wb_en = 1; t.exe_cmd = 4'b0010; t.val_rn = 32'h5; t.dest = 4'd3;
        vecs[0] = '{"cond_pass", t, 1'b1, 1'b0, 1'b0, t};

        t.mem_w_en = 1; t.b = 1;
        vecs[1].name = "cond_fail"; vecs[1].in = t; vecs[1].cond = 0;
        vecs[1].flush = 0; vecs[1].freeze = 0;
        t.wb_en = 0; t.mem_w_en = 0; t.b = 0;
        vecs[1].exp = t;

        t = '0; t.valid = 1; t.pc = 32'h44; t.wb_en = 1; t.b = 1; t.val_rm = 32'hDEAD_BEEF;
        t.sr = 4'hF; t.signed_imm_24 = 24'hABCDEF;
        vecs[2] = '{"flush_freeze", t, 1'b1, 1'b1, 1'b1, fields_t'('0)};

        t = '0; t.valid = 1; t.sr = 4'b1010; t.s = 1;
        vecs[3] = '{"sr_pass", t, 1'b1, 1'b0, 1'b0, t};

        vecs[4].name = "sr_fail"; vecs[4].in = t; vecs[4].cond = 0;
        vecs[4].flush = 0; vecs[4].freeze = 0;
        t.s = 0;
        vecs[4].exp = t;

        t = '0; t.valid = 0; t.pc = 32'h100; t.wb_en = 1; t.mem_r_en = 1; t.shift_operand = 12'h7A5;
        vecs[5].name = "invalid_slot"; vecs[5].in = t; vecs[5].cond = 1;
        vecs[5].flush = 0; vecs[5].freeze = 0;
        t.wb_en = 0; t.mem_r_en = 0;
        vecs[5].exp = t;

        t = '0; t.valid = 1; t.mem_r_en = 1; t.mem_w_en = 1; t.imm = 1; t.dest = 4'hF;
        vecs[6] = '{"rw_both", t, 1'b1, 1'b0, 1'b0, t};

        t = '0; t.valid = 1; t.pc = 32'h8; t.wb_en = 1; t.val_rn = 32'h1234_5678;
        vecs[7] = '{"flush_only", t, 1'b1, 1'b1, 1'b0, fields_t'('0)};

        // Reset state before and across edges.
        #2;
        check("reset_t0", dout, '0);
        din = rand_fields(); din.valid = 1; cond = 1;
        @(posedge clk); #1;
        check("reset_hold", dout, '0);
        rst = 0;
        mdl = '0;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            din = vecs[i].in; cond = vecs[i].cond;
            flush = vecs[i].flush; freeze = vecs[i].freeze;
            step();
            check(vecs[i].name, dout, vecs[i].exp);
        end
        flush = 0; freeze = 0;

        // Freeze holds contents for three edges, then releases one edge later.
        din = '0; din.valid = 1; din.pc = 32'h10; cond = 1;
        step();
        check32("freeze_capture_pc", pc_out, 32'h10);
        freeze = 1; din.pc = 32'h14; din.wb_en = 1;
        for (int i = 0; i < 3; i++) begin
            cond = i[0];
            step();
            check32("freeze_hold_pc", pc_out, 32'h10);
            check("freeze_hold", dout, mdl);
        end
        freeze = 0; cond = 1;
        step();
        check32("freeze_release_pc", pc_out, 32'h14);
        check32("freeze_release_wb", {31'b0, wb_en_out}, 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            din = rand_fields();
            cond = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 7) == 0);
            freeze = ($urandom_range(0, 3) == 0);
            step();
            check("random", dout, mdl);
        end
        flush = 0; freeze = 0;

        // Reset asserted mid-run between edges, including while frozen.
        din = rand_fields(); din.valid = 1; cond = 1;
        step();
        check("pre_reset", dout, mdl);
        rst = 1;
        #1;
        check("reset_async", dout, '0);
        freeze = 1;
        @(posedge clk); #1;
        check("reset_during_freeze", dout, '0);
        rst = 0; freeze = 0;
        mdl = '0;
        din = rand_fields(); din.valid = 1; din.wb_en = 1; cond = 1;
        step();
        check("reset_first_capture", dout, mdl);
        check32("reset_first_pc", pc_out, din.pc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
